// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI word memory responder with a configurable grant stall and response latency.
module obi_mem_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int GNT_STALL  = 0,
    parameter int RESP_LAT   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam logic [2:0] STALL = 3'(GNT_STALL);
    logic [31:0] mem [WORDS];
    logic [2:0] cnt;
    logic hs;
    logic oob;
    logic unused;
    logic [ADDR_WIDTH-3:0] idx;
    logic [RESP_LAT-1:0] vld;
    logic [RESP_LAT-1:0] ebit;
    logic [31:0] dat [RESP_LAT];
    assign gnt_o = req_i && cnt == STALL && rst_ni;
    assign hs = req_i && gnt_o;
    assign oob = |addr_i[31:ADDR_WIDTH];
    assign idx = addr_i[ADDR_WIDTH-1:2];
    assign unused = ^addr_i[1:0];
    assign rvalid_o = vld[RESP_LAT-1];
    assign rdata_o = rvalid_o ? dat[RESP_LAT-1] : '0;
    assign err_o = rvalid_o && ebit[RESP_LAT-1];
    // only control state is reset; data stages are qualified by vld
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            vld <= '0;
        end else begin
            cnt <= (!req_i || hs) ? 3'd0 : (cnt == STALL ? cnt : cnt + 3'd1);
            vld[0] <= hs;
            for (int i = 1; i < RESP_LAT; i++) vld[i] <= vld[i-1];
        end
    end
    always_ff @(posedge clk_i) begin
        if (hs) begin
            dat[0] <= (we_i || oob) ? '0 : mem[idx];
            ebit[0] <= oob;
        end
        for (int i = 1; i < RESP_LAT; i++) begin
            dat[i] <= dat[i-1];
            ebit[i] <= ebit[i-1];
        end
        for (int b = 0; b < 4; b++)
            if (hs && we_i && !oob && be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
    end
endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder: directed checks on three responder configurations sharing one clock and reset.
module tb_obi_mem_responder;
    logic clk = 0;
    logic rst_n;
    logic req [3];
    logic gnt [3];
    logic we [3];
    logic rvalid [3];
    logic err [3];
    logic [3:0] be [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] g;
    logic [7:0] rv;
    logic [31:0] q [$];

    always #5 clk = ~clk;

    // a: no stall, latency 1; b: stall 3, latency 1; c: no stall, latency 3
    obi_mem_responder #(.ADDR_WIDTH(14), .GNT_STALL(0), .RESP_LAT(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
    obi_mem_responder #(.ADDR_WIDTH(14), .GNT_STALL(3), .RESP_LAT(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
    obi_mem_responder #(.ADDR_WIDTH(14), .GNT_STALL(0), .RESP_LAT(3)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
        .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        req[k] = 1;
        we[k] = w;
        addr[k] = a;
        be[k] = b;
        wdata[k] = d;
    endtask

    // single-cycle access on instance a; its response is visible at the following negedge
    task automatic acc_a(input string tag, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        issue(0, w, a, b, d);
        #1 check({tag, "_gnt"}, gnt[0], 1);
        @(negedge clk);
        req[0] = 0;
        check({tag, "_rvalid"}, rvalid[0], 1);
        check({tag, "_rdata"}, rdata[0], exp_d);
        check({tag, "_err"}, err[0], exp_e);
    endtask

    initial begin
        rst_n = 0;
        for (int k = 0; k < 3; k++) issue(k, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) req[k] = 0;
        @(negedge clk);
        issue(0, 0, 32'h0, 4'hF, 0);
        #1 check("rst_gnt", gnt[0], 0);
        check("rst_rvalid", rvalid[0], 0);
        check("rst_rdata", rdata[0], 0);
        check("rst_err", err[0], 0);
        req[0] = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        acc_a("t1_wr", 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        acc_a("t1_rd", 0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0);
        @(negedge clk);
        check("t1_idle_rvalid", rvalid[0], 0);
        check("t1_idle_rdata", rdata[0], 0);
        acc_a("t2_pre", 1, 32'h200, 4'hF, 32'h11223344, 32'h0, 0);
        acc_a("t2_wr", 1, 32'h200, 4'b0101, 32'hAABBCCDD, 32'h0, 0);
        acc_a("t2_rd", 0, 32'h202, 4'hF, 32'h0, 32'h11BB33DD, 0);
        acc_a("t2_be0", 1, 32'h200, 4'h0, 32'hFFFFFFFF, 32'h0, 0);
        acc_a("t2_rd0", 0, 32'h200, 4'hF, 32'h0, 32'h11BB33DD, 0);
        acc_a("t6_w0", 1, 32'h0, 4'hF, 32'h12345678, 32'h0, 0);
        acc_a("t6_rd_oob", 0, 32'h00010000, 4'hF, 32'h0, 32'h0, 1);
        acc_a("t6_wr_oob", 1, 32'h00010000, 4'hF, 32'hFFFFFFFF, 32'h0, 1);
        acc_a("t6_rd0", 0, 32'h0, 4'hF, 32'h0, 32'h12345678, 0);
        // stalled grant on b: fourth cycle of a held request, and again for a back-to-back one
        issue(1, 1, 32'h8, 4'hF, 32'h5A5A5A5A);
        g = 0;
        for (int i = 0; i < 4; i++) begin
            #1 g[i] = gnt[1];
            @(negedge clk);
        end
        issue(1, 0, 32'h8, 4'hF, 0);
        check("t3_gnt_seq", g, 8'b1000);
        check("t3_wr_rvalid", rvalid[1], 1);
        g = 0;
        for (int i = 0; i < 4; i++) begin
            #1 g[i] = gnt[1];
            @(negedge clk);
        end
        req[1] = 0;
        check("t3_b2b_seq", g, 8'b1000);
        check("t3_rd_rvalid", rvalid[1], 1);
        check("t3_rd_rdata", rdata[1], 32'h5A5A5A5A);
        issue(1, 1, 32'h8, 4'hF, 32'hFFFFFFFF);
        g = 0;
        for (int i = 0; i < 2; i++) begin
            #1 g[i] = gnt[1];
            @(negedge clk);
        end
        req[1] = 0;
        rv = 0;
        for (int i = 0; i < 4; i++) begin
            #1 rv[i] = rvalid[1];
            @(negedge clk);
        end
        check("t3_abn_gnt", g, 0);
        check("t3_abn_rvalid", rv, 0);
        issue(1, 0, 32'h8, 4'hF, 0);
        g = 0;
        for (int i = 0; i < 4; i++) begin
            #1 g[i] = gnt[1];
            @(negedge clk);
        end
        req[1] = 0;
        check("t3_restart_seq", g, 8'b1000);
        check("t3_restart_rdata", rdata[1], 32'h5A5A5A5A);
        // back-to-back reads on c with latency 3
        for (int i = 0; i < 4; i++) begin
            issue(2, 1, 32'(4 * i), 4'hF, 32'hA0A00000 | 32'(i));
            @(negedge clk);
        end
        req[2] = 0;
        repeat (4) @(negedge clk);
        rv = 0;
        for (int i = 0; i < 8; i++) begin
            rv[i] = rvalid[2];
            if (rvalid[2]) q.push_back(rdata[2]);
            if (i < 4) issue(2, 0, 32'(4 * i), 4'hF, 0);
            else req[2] = 0;
            @(negedge clk);
        end
        check("t4_rvalid_seq", rv, 8'b0111_1000);
        for (int j = 0; j < 4; j++)
            check("t4_rdata", j < q.size() ? q[j] : 32'hFFFFFFFF, 32'hA0A00000 | 32'(j));
        // reset with two reads in flight on c
        issue(2, 0, 32'h4, 4'hF, 0);
        @(negedge clk);
        issue(2, 0, 32'h8, 4'hF, 0);
        @(negedge clk);
        req[2] = 0;
        rst_n = 0;
        #1 check("t5_rst_rvalid", rvalid[2], 0);
        issue(2, 0, 32'h0, 4'hF, 0);
        #1 check("t5_rst_gnt", gnt[2], 0);
        req[2] = 0;
        @(negedge clk);
        rst_n = 1;
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            rv[i] = rvalid[2];
            @(negedge clk);
        end
        check("t5_post_rvalid", rv, 0);
        issue(2, 0, 32'h4, 4'hF, 0);
        @(negedge clk);
        req[2] = 0;
        repeat (2) @(negedge clk);
        check("t5_rd_rvalid", rvalid[2], 1);
        check("t5_rd_rdata", rdata[2], 32'hA0A00001);
        acc_a("t5_a_persist", 0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
